// File: rtl/register_arbiter_if.sv
// -----------------------------------------------------------------------------
// register_arbiter_if
//
// Bundles the requester-side handshake and the shared-register write port of
// register_arbiter into one interface.
//
//   s_valid          [NUM_REQ]             per-requester write request
//   s_data           [NUM_REQ*WORD_WIDTH]  packed words, requester i at
//                                          [i*WORD_WIDTH +: WORD_WIDTH]
//   s_last           [NUM_REQ]             current beat ends the burst
//   s_ready          [NUM_REQ]             per-requester accept (one-hot or 0)
//   reg_clock_enable                       enable for the shared register
//   reg_data_in      [WORD_WIDTH]          data for the shared register
//   reg_owner        [OWNER_W]             requester that produced reg_data_in
//
// Modports:
//   master - requester side: drives the s_* request signals, observes the rest
//   slave  - arbiter side:   consumes requests, drives s_ready and reg_*
// -----------------------------------------------------------------------------
interface register_arbiter_if #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_REQ    = 4
);

  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            s_valid;
  logic [NUM_REQ*WORD_WIDTH-1:0] s_data;
  logic [NUM_REQ-1:0]            s_last;
  logic [NUM_REQ-1:0]            s_ready;
  logic                          reg_clock_enable;
  logic [WORD_WIDTH-1:0]         reg_data_in;
  logic [OWNER_W-1:0]            reg_owner;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready,
    input  reg_clock_enable,
    input  reg_data_in,
    input  reg_owner
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready,
    output reg_clock_enable,
    output reg_data_in,
    output reg_owner
  );

endinterface : register_arbiter_if

// File: rtl/register_arbiter.sv
// -----------------------------------------------------------------------------
// register_arbiter
//
// Shares one downstream register between NUM_REQ requesters. A requester is
// picked round-robin while IDLE, then owns the register (LOCKED) until it
// sends a beat flagged s_last or until MAX_BURST beats have been transferred.
// Every accepted beat is registered onto reg_data_in / reg_owner together
// with a one-cycle reg_clock_enable pulse.
//
// Ports:
//   clock  - single clock, all state updates on the rising edge
//   reset  - synchronous, active-high reset
//   bus    - register_arbiter_if.slave (s_valid/s_data/s_last in,
//            s_ready/reg_clock_enable/reg_data_in/reg_owner out)
//
// Parameters:
//   WORD_WIDTH - width of each data word
//   NUM_REQ    - number of requesters (2..16)
//   MAX_BURST  - beats per grant before the grant is forcibly released (1..255)
// -----------------------------------------------------------------------------
module register_arbiter #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                clock,
  input  logic                reset,
  register_arbiter_if.slave   bus
);

  localparam int OWNER_W = $clog2(NUM_REQ);

  typedef logic [OWNER_W-1:0] owner_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state_q,     state_d;
  owner_t                rr_ptr_q,    rr_ptr_d;
  owner_t                grant_q,     grant_d;
  logic [7:0]            beat_cnt_q,  beat_cnt_d;
  logic                  reg_ce_q,    reg_ce_d;
  logic [WORD_WIDTH-1:0] reg_data_q,  reg_data_d;
  owner_t                reg_owner_q, reg_owner_d;

  // ---------------------------------------------------------------------------
  // Round-robin search: first requester with s_valid high, starting at
  // rr_ptr_q and wrapping past NUM_REQ-1 back to 0.
  // ---------------------------------------------------------------------------
  logic        found;
  owner_t      winner;
  int unsigned scan_idx;
  owner_t      scan_sel;

  // NOTE: every variable written in a combinational block gets a default at
  // the top; a path that leaves one unassigned would infer a latch.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    scan_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      scan_sel = owner_t'(scan_idx);
      if (!found && bus.s_valid[scan_sel]) begin
        found  = 1'b1;
        winner = scan_sel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Owner-side view. Non-granted requesters are never looked at while LOCKED.
  // ---------------------------------------------------------------------------
  logic                  gnt_valid;
  logic                  gnt_last;
  logic [WORD_WIDTH-1:0] gnt_data;
  logic                  xfer;
  logic [7:0]            beat_cnt_inc;
  logic                  burst_done;
  owner_t                rr_next;

  assign gnt_valid    = bus.s_valid[grant_q];
  assign gnt_last     = bus.s_last[grant_q];
  assign gnt_data     = bus.s_data[int'(grant_q)*WORD_WIDTH +: WORD_WIDTH];

  // s_ready[grant_q] is high exactly when LOCKED, so the handshake reduces to
  // the owner's valid while LOCKED.
  assign xfer         = (state_q == LOCKED) && gnt_valid;

  assign beat_cnt_inc = beat_cnt_q + 8'd1;

  // Release on an explicit last beat or on the beat that reaches MAX_BURST.
  assign burst_done   = gnt_last || (beat_cnt_inc == MAX_BURST_C);

  assign rr_next      = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. The release edge always goes to IDLE, so the next
  // grant is decided in the following IDLE cycle, never in the release cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && burst_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic. Only the owner sees ready, and only while LOCKED; the
  // cycle after a reset edge is IDLE, so ready drops with reset.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] s_ready_c;

  always_comb begin
    s_ready_c = '0;
    if (state_q == LOCKED) begin
      s_ready_c[grant_q] = 1'b1;
    end
  end

  assign bus.s_ready = s_ready_c;

  // ---------------------------------------------------------------------------
  // Datapath next-state: grant capture, beat counting, pointer advance and
  // the shared-register write port.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    reg_ce_d    = 1'b0;
    reg_data_d  = reg_data_q;
    reg_owner_d = reg_owner_q;

    if ((state_q == IDLE) && found) begin
      grant_d    = winner;
      beat_cnt_d = '0;
    end

    if (xfer) begin
      reg_ce_d    = 1'b1;
      reg_data_d  = gnt_data;
      reg_owner_d = grant_q;
      beat_cnt_d  = beat_cnt_inc;
      if (burst_done) begin
        rr_ptr_d = rr_next;
      end
    end
  end

  // NOTE: reset is synchronous and wins over a handshake on the same edge;
  // every register here is control or visible output, so all of them reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      reg_ce_q    <= 1'b0;
      reg_data_q  <= '0;
      reg_owner_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      reg_ce_q    <= reg_ce_d;
      reg_data_q  <= reg_data_d;
      reg_owner_q <= reg_owner_d;
    end
  end

  assign bus.reg_clock_enable = reg_ce_q;
  assign bus.reg_data_in      = reg_data_q;
  assign bus.reg_owner        = reg_owner_q;

endmodule : register_arbiter

// File: tb/tb_register_arbiter.sv
// -----------------------------------------------------------------------------
// tb_register_arbiter
//
// Requester sources are queues of beats driven on the falling edge; each beat
// may carry a number of cycles to hold s_valid low before it is presented.
// Stimulus pushes hand-computed expected register writes (data, owner, cycles
// since the previous write) into a scoreboard queue; a monitor pops and
// compares on every reg_clock_enable pulse, and also checks every cycle that
// s_ready is one-hot/zero and that each pulse follows exactly one handshake.
// -----------------------------------------------------------------------------
module tb_register_arbiter;

  localparam int WW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  typedef struct {
    logic [WW-1:0] data;
    logic          last;
    int            delay;
  } beat_t;

  typedef struct {
    logic [WW-1:0] data;
    logic [1:0]    owner;
    int            gap;   // 0 = do not check spacing
  } exp_t;

  logic clock;
  logic reset;

  register_arbiter_if #(.WORD_WIDTH(WW), .NUM_REQ(NR)) bus ();

  register_arbiter #(
    .WORD_WIDTH (WW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  beat_t src_q [NR][$];
  exp_t  exp_q [$];

  logic [NR-1:0] hs = '0;
  int            hs_total = 0;
  int            ce_total = 0;
  int            cycle = 0;
  int            last_pulse = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push_beat(input int r, input logic [WW-1:0] d, input logic l,
                           input int dly);
    beat_t b;
    b.data  = d;
    b.last  = l;
    b.delay = dly;
    src_q[r].push_back(b);
  endtask

  task automatic expect_wr(input logic [WW-1:0] d, input logic [1:0] o, input int g);
    exp_t e;
    e.data  = d;
    e.owner = o;
    e.gap   = g;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Requester driver: update on negedge, sample the handshake 1 before posedge.
  // ---------------------------------------------------------------------------
  logic [NR-1:0]    drv_valid;
  logic [NR*WW-1:0] drv_data;
  logic [NR-1:0]    drv_last;
  beat_t            drv_b;

  initial begin
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.s_last  = '0;
    forever begin
      @(negedge clock);
      drv_valid = '0;
      drv_data  = '0;
      drv_last  = '0;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && (src_q[i].size() > 0)) begin
          void'(src_q[i].pop_front());
        end
        if (src_q[i].size() > 0) begin
          drv_b = src_q[i][0];
          if (drv_b.delay > 0) begin
            drv_b.delay = drv_b.delay - 1;
            src_q[i][0] = drv_b;
          end else begin
            drv_valid[i]          = 1'b1;
            drv_data[i*WW +: WW]  = drv_b.data;
            drv_last[i]           = drv_b.last;
          end
        end
      end
      bus.s_valid = drv_valid;
      bus.s_data  = drv_data;
      bus.s_last  = drv_last;
      #4;
      hs = bus.s_valid & bus.s_ready & {NR{~reset}};
      hs_total = hs_total + $countones(hs);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  exp_t mon_e;

  always begin
    @(negedge clock);
    cycle++;
    check("ready_onehot0", 32'($onehot0(bus.s_ready)), 32'd1);
    check("ce_follows_handshake", 32'(bus.reg_clock_enable), 32'(|hs));
    if (bus.reg_clock_enable === 1'b1) begin
      ce_total++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: data 0x%0h owner %0d, nothing expected (t=%0t)",
                 bus.reg_data_in, bus.reg_owner, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("reg_data_in", 32'(bus.reg_data_in), 32'(mon_e.data));
        check("reg_owner", 32'(bus.reg_owner), 32'(mon_e.owner));
        if (mon_e.gap != 0) begin
          check("write_spacing", 32'(cycle - last_pulse), 32'(mon_e.gap));
        end
      end
      last_pulse = cycle;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (main thread runs at posedge+2)
  // ---------------------------------------------------------------------------
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      @(posedge clock); #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected writes missing after %0d cycles", name,
               exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (2) @(posedge clock);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    check({tag, "_reg_ce"}, 32'(bus.reg_clock_enable), 32'd0);
    check({tag, "_reg_data"}, 32'(bus.reg_data_in), 32'd0);
    check({tag, "_reg_owner"}, 32'(bus.reg_owner), 32'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #2;
    check_reset_outputs("reset");
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    check_reset_outputs("por");
    reset = 1'b0;

    // Single beat on requester 1: ready one cycle after valid, write next cycle.
    push_beat(1, 8'd5, 1'b1, 0);
    expect_wr(8'd5, 2'd1, 0);
    @(posedge clock); #2;
    check("single_ready_latency", 32'(bus.s_ready), 32'b0010);
    drain("single_beat", 20);

    // rr_pointer is now 2: requester 2 wins over 0, then 0 after one idle cycle.
    push_beat(0, 8'h20, 1'b1, 0);
    push_beat(2, 8'h22, 1'b1, 0);
    expect_wr(8'h22, 2'd2, 0);
    expect_wr(8'h20, 2'd0, 2);
    drain("rr_after_single", 30);

    // Round-robin over all four single-beat requesters: 0,1,2,3,0.
    do_reset(1);
    push_beat(0, 8'h30, 1'b1, 0);
    push_beat(0, 8'h34, 1'b1, 0);
    push_beat(1, 8'h31, 1'b1, 0);
    push_beat(2, 8'h32, 1'b1, 0);
    push_beat(3, 8'h33, 1'b1, 0);
    expect_wr(8'h30, 2'd0, 0);
    expect_wr(8'h31, 2'd1, 2);
    expect_wr(8'h32, 2'd2, 2);
    expect_wr(8'h33, 2'd3, 2);
    expect_wr(8'h34, 2'd0, 2);
    drain("round_robin", 60);

    // Forced release after MAX_BURST beats; 12 needs a fresh grant.
    for (int d = 8; d <= 12; d++) begin
      push_beat(2, 8'(d), 1'b0, 0);
    end
    expect_wr(8'd8,  2'd2, 0);
    expect_wr(8'd9,  2'd2, 1);
    expect_wr(8'd10, 2'd2, 1);
    expect_wr(8'd11, 2'd2, 1);
    expect_wr(8'd12, 2'd2, 2);
    drain("forced_release", 40);
    // Owner has gone quiet without s_last: the grant stays with it.
    check("stalled_owner_keeps_grant", 32'(bus.s_ready), 32'b0100);
    do_reset(1);

    // Stall: owner 1 drops valid for 3 cycles; requester 3 must wait.
    push_beat(1, 8'h40, 1'b0, 0);
    push_beat(1, 8'h41, 1'b0, 0);
    push_beat(1, 8'h42, 1'b0, 3);
    push_beat(1, 8'h43, 1'b1, 0);
    push_beat(3, 8'h53, 1'b1, 0);
    expect_wr(8'h40, 2'd1, 0);
    expect_wr(8'h41, 2'd1, 1);
    expect_wr(8'h42, 2'd1, 4);
    expect_wr(8'h43, 2'd1, 1);
    expect_wr(8'h53, 2'd3, 2);
    drain("stall", 60);

    // Move rr_pointer away from 0 so the post-reset grant order is telling.
    push_beat(1, 8'h5A, 1'b1, 0);
    expect_wr(8'h5A, 2'd1, 0);
    drain("rr_advance", 20);

    // Reset for 2 cycles in the middle of a 4-beat burst on requester 2.
    push_beat(2, 8'h60, 1'b0, 0);
    push_beat(2, 8'h61, 1'b0, 0);
    push_beat(2, 8'h62, 1'b0, 0);
    push_beat(2, 8'h63, 1'b1, 0);
    expect_wr(8'h60, 2'd2, 0);
    expect_wr(8'h61, 2'd2, 1);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;               // lands on the edge that would take beat 0x62
    @(posedge clock); #2;
    check_reset_outputs("mid_burst");
    src_q[2].delete();          // source abandons the rest of its burst
    @(posedge clock); #2;
    check_reset_outputs("mid_burst2");
    reset = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_burst_prefix: %0d writes missing before reset", exp_q.size());
      exp_q.delete();
    end

    // After reset the search starts at requester 0 again.
    push_beat(0, 8'h70, 1'b1, 0);
    push_beat(2, 8'h72, 1'b1, 0);
    expect_wr(8'h70, 2'd0, 0);
    expect_wr(8'h72, 2'd2, 2);
    drain("post_reset_order", 30);

    check("pulses_equal_handshakes", 32'(ce_total), 32'(hs_total));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_register_arbiter

// File: doc/register_arbiter.md
REGISTER_ARBITER -- requirements
Module: register_arbiter

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, width of each data word.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant before forced release (1..255).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  NUM_REQ  per-requester write request, bit i = requester i.
REQ-007 SHALL have port s_data  input  NUM_REQ*WORD_WIDTH  packed words; requester i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-008 SHALL have port s_last  input  NUM_REQ  per-requester marker that the current beat ends the burst.
REQ-009 SHALL have port s_ready  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-010 SHALL have port reg_clock_enable  output  1  enable for the shared downstream register.
REQ-011 SHALL have port reg_data_in  output  WORD_WIDTH  data for the shared register.
REQ-012 SHALL have port reg_owner  output  clog2(NUM_REQ)  index of the requester whose beat is on reg_data_in.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-014 SHALL, in IDLE with any s_valid high, select the first requester with s_valid high, searching round-robin from rr_pointer upward with wrap, store it as grant_id, and move to LOCKED next cycle (1-cycle arbitration latency).
REQ-015 SHALL, in IDLE with no s_valid high, stay in IDLE.
REQ-016 SHALL drive s_ready[grant_id]=1 combinationally only in LOCKED; all other s_ready bits 0; all bits 0 in IDLE.
REQ-017 SHALL count a beat as transferred when s_valid[grant_id] and s_ready[grant_id] are both high on a rising edge.
REQ-018 SHALL, for each transferred beat, register reg_clock_enable=1, reg_data_in=that requester's word, and reg_owner=grant_id on the same edge (output valid 1 cycle after the handshake).
REQ-019 SHALL hold reg_clock_enable=0 in any cycle not following a transfer; reg_data_in and reg_owner hold their last values.
REQ-020 SHALL keep an 8-bit beat counter, cleared on entry to LOCKED and incremented per transfer.
REQ-021 SHALL return to IDLE after a transfer with s_last[grant_id]=1, or after the transfer that makes the beat count equal MAX_BURST, whichever comes first.
REQ-022 SHALL, on every return to IDLE, set rr_pointer to (grant_id+1) mod NUM_REQ.
REQ-023 SHALL, in LOCKED with s_valid[grant_id] low, stay LOCKED with no transfer (a stalled owner keeps the grant).
REQ-024 SHALL ignore s_valid, s_data and s_last of non-granted requesters while LOCKED.
REQ-025 SHALL not re-arbitrate in the release cycle; the next grant is decided in the following IDLE cycle (minimum 1 idle cycle between bursts).

Reset
REQ-026 SHALL, while reset is high at a rising edge, force state=IDLE, rr_pointer=0, grant_id=0, beat counter=0, reg_clock_enable=0, reg_data_in=0, reg_owner=0.
REQ-027 SHALL, when reset is asserted mid-burst, abandon the burst with no further reg_clock_enable pulse, and s_ready SHALL be all zero from the cycle after the reset edge.
REQ-028 SHALL take reset precedence over any simultaneous handshake.

Verification
REQ-029 SHALL cover single beat: after reset, s_valid=0b0010, s_data[1]=5, s_last[1]=1 -> s_ready[1] high 1 cycle later; next cycle reg_clock_enable=1, reg_data_in=5, reg_owner=1; rr_pointer=2.
REQ-030 SHALL cover round-robin: all four requesters valid with single-beat bursts (s_last=1) -> grants in order 0,1,2,3,0 with one IDLE cycle between each.
REQ-031 SHALL cover forced release: requester 2 streams data 8,9,10,11,12 with s_last=0, MAX_BURST=4 -> reg_data_in sequence 8,9,10,11, then release; 12 is only delivered after a new grant.
REQ-032 SHALL cover stall: owner drops s_valid for 3 cycles mid-burst -> grant held, reg_clock_enable=0 for those cycles, no other s_ready bit rises.
REQ-033 SHALL cover reset mid-burst: reset high for 2 cycles during a 4-beat burst -> outputs at reset values, next grant starts at requester 0.
REQ-034 SHALL check in every cycle that s_ready is one-hot or zero and that reg_clock_enable pulses equal the handshake count.
